// File: rtl/sram_mem_controller_pkg.sv
// Shared definitions for the MEM-stage SRAM controller: FSM states,
// bus widths, the default data-segment base and the word-index helper.
package sram_mem_controller_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        DONE
    } state_t;

    localparam logic [31:0] DATA_BASE   = 32'd1024;
    localparam int          SRAM_ADDR_W = 18;
    localparam int          SRAM_DATA_W = 16;
    localparam int          WORD_W      = 32;
    localparam int          INDEX_W     = SRAM_ADDR_W - 1;

    // Byte address -> 32-bit word index inside the SRAM. The subtraction
    // wraps modulo 2^32, so addresses below the base alias to the top of SRAM.
    function automatic logic [INDEX_W-1:0] word_index(input logic [WORD_W-1:0] addr,
                                                      input logic [WORD_W-1:0] base);
        return INDEX_W'((addr - base) >> 2);
    endfunction

endpackage

// File: rtl/sram_mem_controller_if.sv
// Pipeline-side bus between the EX/MEM register and the MEM-stage
// controller: request, operands, load result and the stall handshake.
interface sram_mem_controller_if;
    import sram_mem_controller_pkg::*;

    logic              wr_en;
    logic              rd_en;
    logic [WORD_W-1:0] address;
    logic [WORD_W-1:0] write_data;
    logic [WORD_W-1:0] read_data;
    logic              ready;

    modport master (
        output wr_en, rd_en, address, write_data,
        input  read_data, ready
    );

    modport slave (
        input  wr_en, rd_en, address, write_data,
        output read_data, ready
    );
endinterface

// File: rtl/sram_tristate_buf.sv
// Bidirectional pad driver for the SRAM data bus: drives dout when oe is
// high, releases the bus otherwise, and always returns what is on the pins.
module sram_tristate_buf
    import sram_mem_controller_pkg::*;
(
    input  logic                   oe,
    input  logic [SRAM_DATA_W-1:0] dout,
    output logic [SRAM_DATA_W-1:0] din,
    inout  wire  [SRAM_DATA_W-1:0] pad
);

    assign pad = oe ? dout : {SRAM_DATA_W{1'bz}};
    assign din = pad;

endmodule

// File: rtl/sram_mem_controller.sv
// MEM-stage memory controller: splits one 32-bit load/store into two
// 16-bit accesses on an asynchronous SRAM, low half first, and holds
// ready low so the hazard logic freezes the earlier pipeline stages.
module sram_mem_controller
    import sram_mem_controller_pkg::state_t,
           sram_mem_controller_pkg::IDLE,
           sram_mem_controller_pkg::LOW,
           sram_mem_controller_pkg::HIGH,
           sram_mem_controller_pkg::DONE,
           sram_mem_controller_pkg::SRAM_ADDR_W,
           sram_mem_controller_pkg::SRAM_DATA_W,
           sram_mem_controller_pkg::INDEX_W,
           sram_mem_controller_pkg::word_index;
#(
    parameter logic [31:0] DATA_BASE     = sram_mem_controller_pkg::DATA_BASE,
    parameter int unsigned ACCESS_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    sram_mem_controller_if.slave   bus,
    inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic                   SRAM_WE_N,
    output logic                   SRAM_OE_N,
    output logic                   SRAM_CE_N,
    output logic                   SRAM_UB_N,
    output logic                   SRAM_LB_N
);

    // Counter runs 0 .. ACCESS_CYCLES-1 within each half access.
    localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);

    state_t                 state_q;
    state_t                 state_d;
    logic [3:0]             cnt_q;
    logic                   op_wr_q;
    logic [INDEX_W-1:0]     idx_q;
    logic [31:0]            wdata_q;
    logic [31:0]            rdata_q;
    logic                   req;
    logic                   last_cycle;
    logic                   drive_en;
    logic [SRAM_DATA_W-1:0] dq_out;
    logic [SRAM_DATA_W-1:0] dq_in;

    assign req        = bus.wr_en | bus.rd_en;
    assign last_cycle = (cnt_q == LAST_CNT);

    // State register; reset abandons any access in flight.
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic: each half lasts ACCESS_CYCLES, DONE lasts one cycle.
    // NOTE: state_d gets its default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req)        state_d = LOW;
            LOW:     if (last_cycle) state_d = HIGH;
            HIGH:    if (last_cycle) state_d = DONE;
            DONE:                    state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    // Stall handshake and write strobe decoded from the current state.
    always_comb begin
        bus.ready = 1'b0;
        drive_en  = 1'b0;
        case (state_q)
            IDLE:      bus.ready = !req;
            LOW, HIGH: drive_en  = op_wr_q;
            DONE:      bus.ready = 1'b1;
            default:   ;
        endcase
    end

    // Operand capture in IDLE (a store wins over a load) and the half-cycle counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            op_wr_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (req) begin
                    cnt_q   <= '0;
                    op_wr_q <= bus.wr_en;
                    idx_q   <= word_index(bus.address, DATA_BASE);
                    wdata_q <= bus.write_data;
                end
                LOW, HIGH: cnt_q <= last_cycle ? '0 : cnt_q + 4'd1;
                default: ;
            endcase
        end
    end

    // Load result: each half is sampled from the pins on its last access cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (!op_wr_q && last_cycle) begin
            if (state_q == LOW)       rdata_q[15:0]  <= dq_in;
            else if (state_q == HIGH) rdata_q[31:16] <= dq_in;
        end
    end

    assign bus.read_data = rdata_q;
    assign dq_out        = (state_q == HIGH) ? wdata_q[31:16] : wdata_q[15:0];
    assign SRAM_ADDR     = {idx_q, state_q == HIGH};
    assign SRAM_WE_N     = !drive_en;
    assign SRAM_OE_N     = 1'b0;
    assign SRAM_CE_N     = 1'b0;
    assign SRAM_UB_N     = 1'b0;
    assign SRAM_LB_N     = 1'b0;

    sram_tristate_buf u_dq_buf (
        .oe   (drive_en),
        .dout (dq_out),
        .din  (dq_in),
        .pad  (SRAM_DQ)
    );

endmodule

// File: tb/tb_sram_mem_controller.sv
// Bench for sram_mem_controller: directed vector table, held back-to-back
// requests, reset mid-store, and randomized traffic against a word-level
// reference model of memory contents and load results.
module tb_sram_mem_controller;
    import sram_mem_controller_pkg::*;

    localparam int          AC   = 2;
    localparam logic [31:0] BASE = 32'd1024;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_mem_controller_if bus ();

    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        we_n, oe_n, ce_n, ub_n, lb_n;

    sram_mem_controller #(
        .DATA_BASE     (BASE),
        .ACCESS_CYCLES (AC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .SRAM_DQ   (sram_dq),
        .SRAM_ADDR (sram_addr),
        .SRAM_WE_N (we_n),
        .SRAM_OE_N (oe_n),
        .SRAM_CE_N (ce_n),
        .SRAM_UB_N (ub_n),
        .SRAM_LB_N (lb_n)
    );

    // Preloaded SRAM content pattern, shared by the device model and the reference.
    function automatic logic [15:0] init_val(input int a);
        return 16'((a * 40503) ^ 23130);
    endfunction

    // Asynchronous SRAM model: outputs the addressed word whenever not writing.
    logic [15:0] env_mem [0:(1<<18)-1];
    logic [15:0] env_rd;
    assign env_rd  = env_mem[sram_addr];
    assign sram_dq = we_n ? env_rd : 16'hzzzz;
    always @(negedge clk) begin
        if (!we_n) env_mem[sram_addr] <= sram_dq;
    end

    // Reference model: half-word array plus the last load result.
    logic [15:0] ref_mem [int];
    logic [31:0] model_rdata;

    function automatic logic [15:0] ref_rd(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    function automatic int half_addr(input logic [31:0] addr);
        return int'(((addr - BASE) / 32'd4) % 32'd131072) * 2;
    endfunction

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic idle_inputs();
        bus.wr_en      = 1'b0;
        bus.rd_en      = 1'b0;
        bus.address    = '0;
        bus.write_data = '0;
    endtask

    // One complete request starting at the next falling edge; checks every cycle.
    task automatic do_txn(input bit wr, input bit rd, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit hold, input bit scr,
                          input logic [17:0] exp_lo, input logic [31:0] exp_rd);
        int ha;
        logic [15:0] exp_half;
        ha = half_addr(addr);
        @(negedge clk);
        bus.wr_en      = wr;
        bus.rd_en      = rd;
        bus.address    = addr;
        bus.write_data = wdata;
        #1;
        check("req_ready", 32'(bus.ready), 32'd0);
        for (int c = 1; c <= 2 * AC; c++) begin
            @(negedge clk);
            if (scr) begin
                bus.wr_en      = 1'($urandom);
                bus.rd_en      = 1'($urandom);
                bus.address    = $urandom;
                bus.write_data = $urandom;
            end
            #1;
            check("busy_ready", 32'(bus.ready), 32'd0);
            check("busy_addr", 32'(sram_addr), 32'(exp_lo + ((c > AC) ? 18'd1 : 18'd0)));
            check("busy_we_n", 32'(we_n), wr ? 32'd0 : 32'd1);
            if (wr) begin
                exp_half = (c > AC) ? wdata[31:16] : wdata[15:0];
                check("busy_dq", 32'(sram_dq), 32'(exp_half));
            end
        end
        @(negedge clk);
        #1;
        check("done_ready", 32'(bus.ready), 32'd1);
        check("done_rdata", bus.read_data, exp_rd);
        check("done_we_n", 32'(we_n), 32'd1);
        if (wr) begin
            ref_mem[ha]     = wdata[15:0];
            ref_mem[ha + 1] = wdata[31:16];
            check("sram_lo", 32'(env_mem[ha]), 32'(wdata[15:0]));
            check("sram_hi", 32'(env_mem[ha + 1]), 32'(wdata[31:16]));
        end else begin
            model_rdata = exp_rd;
        end
        if (!hold) idle_inputs();
    endtask

    typedef struct {
        bit          wr;
        bit          rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          hold;
        bit          scr;
        logic [17:0] exp_lo;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [9];

    initial begin
        vecs[0] = '{1'b1, 1'b0, 32'd1032, 32'hDEADBEEF, 1'b0, 1'b0, 18'd4,       32'h00000000};
        vecs[1] = '{1'b0, 1'b1, 32'd1032, 32'h00000000, 1'b0, 1'b0, 18'd4,       32'hDEADBEEF};
        vecs[2] = '{1'b0, 1'b1, 32'd1024, 32'h00000000, 1'b1, 1'b0, 18'd0,       32'hC46D5A5A};
        vecs[3] = '{1'b1, 1'b0, 32'd1028, 32'hA5A50F0F, 1'b1, 1'b0, 18'd2,       32'hC46D5A5A};
        vecs[4] = '{1'b1, 1'b1, 32'd1024, 32'h12345678, 1'b0, 1'b0, 18'd0,       32'hC46D5A5A};
        vecs[5] = '{1'b0, 1'b1, 32'd1024, 32'h00000000, 1'b0, 1'b0, 18'd0,       32'h12345678};
        vecs[6] = '{1'b1, 1'b0, 32'd1020, 32'hCAFEF00D, 1'b0, 1'b0, 18'h3FFFE,   32'h12345678};
        vecs[7] = '{1'b0, 1'b1, 32'd1021, 32'h00000000, 1'b0, 1'b0, 18'h3FFFE,   32'hCAFEF00D};
        vecs[8] = '{1'b0, 1'b1, 32'd1028, 32'h00000000, 1'b0, 1'b1, 18'd2,       32'hA5A50F0F};

        for (int a = 0; a < (1 << 18); a++) env_mem[a] = init_val(a);
        model_rdata = '0;
        idle_inputs();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_rdata", bus.read_data, 32'd0);
        check("rst_we_n", 32'(we_n), 32'd1);
        check("rst_addr", 32'(sram_addr), 32'd0);
        check("rst_dq", 32'(sram_dq), 32'(init_val(0)));
        check("tied_pins", {28'd0, oe_n, ce_n, ub_n, lb_n}, 32'd0);

        // Directed vectors, including held back-to-back requests.
        for (int i = 0; i < 9; i++)
            do_txn(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata,
                   vecs[i].hold, vecs[i].scr, vecs[i].exp_lo, vecs[i].exp_rd);

        // Load result holds while idle.
        repeat (3) begin
            @(negedge clk);
            #1;
            check("hold_ready", 32'(bus.ready), 32'd1);
            check("hold_rdata", bus.read_data, 32'hA5A50F0F);
        end

        // Randomized traffic against the reference model.
        for (int i = 0; i < 30; i++) begin
            logic [31:0] addr;
            logic [31:0] wdata;
            logic [31:0] exp_rd;
            int          op;
            int          ha;
            bit          hold;
            bit          scr;
            op    = int'($urandom_range(0, 2));
            addr  = BASE + 32'(4 * $urandom_range(0, 63)) + 32'($urandom_range(0, 3));
            wdata = $urandom;
            hold  = 1'($urandom_range(0, 1));
            scr   = !hold && ($urandom_range(0, 1) == 1);
            ha    = half_addr(addr);
            exp_rd = (op != 0) ? model_rdata : {ref_rd(ha + 1), ref_rd(ha)};
            do_txn(op != 0, op != 1, addr, wdata, hold, scr, 18'(ha), exp_rd);
            if (!hold && $urandom_range(0, 2) == 0) begin
                @(negedge clk);
                #1;
                check("gap_ready", 32'(bus.ready), 32'd1);
            end
        end
        idle_inputs();

        // Reset asserted during the HIGH half of a store.
        @(negedge clk);
        bus.wr_en      = 1'b1;
        bus.address    = BASE + 32'd400;
        bus.write_data = 32'h55AA33CC;
        #1;
        check("mid_req_ready", 32'(bus.ready), 32'd0);
        repeat (AC + 1) @(negedge clk);
        #1;
        check("mid_high_we_n", 32'(we_n), 32'd0);
        idle_inputs();
        rst = 1'b1;
        #1;
        check("mid_rst_ready", 32'(bus.ready), 32'd1);
        check("mid_rst_we_n", 32'(we_n), 32'd1);
        check("mid_rst_rdata", bus.read_data, 32'd0);
        check("mid_rst_addr", 32'(sram_addr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("post_rst_ready", 32'(bus.ready), 32'd1);
        check("post_rst_we_n", 32'(we_n), 32'd1);
        check("post_rst_dq", 32'(sram_dq), 32'(ref_rd(0)));
        model_rdata = '0;
        do_txn(1'b0, 1'b1, 32'd1032, 32'd0, 1'b0, 1'b0, 18'd4,
               {ref_rd(5), ref_rd(4)});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Bound on total run time.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "timeout");
    end

endmodule
